sync_fifo_rd_stream: RTL
========================

// Module: sync_fifo_rd_stream
// PURPOSE
//   Downstream read-side adapter for sync_fifo. Converts the FIFO read port
//   (renable/rdata/empty, fixed read latency) into a valid/ready stream.
//   Prefetches ahead into a small output buffer so a consumer holding m_ready
//   high gets one word per rclk cycle. fifo_renable depends only on registered
//   state and fifo_empty, never on m_ready.
// PARAMETERS
//   DW     32  data width; equals the FIFO DW
//   RD_LAT 1   cycles from fifo_renable high to fifo_rdata valid (legal 1..3)
//   BD     RD_LAT+2 (localparam) output buffer depth; sized for full
//              throughput with no m_ready->renable combinational path
// PORTS
//   rclk          in   1             read-domain clock; all logic on posedge
//   rst           in   1             synchronous reset, active-high
//   fifo_empty    in   1             FIFO empty flag
//   fifo_renable  out  1             FIFO read strobe, one word per high cycle
//   fifo_rdata    in   DW            FIFO read data, valid RD_LAT cycles after renable
//   flush         in   1             1-cycle pulse: discard buffered and in-flight words
//   m_valid       out  1             head word available
//   m_data        out  DW            head word; stable while m_valid & !m_ready
//   m_ready       in   1             consumer accepts head when m_valid & m_ready
//   level         out  $clog2(BD+1)  words currently held in the buffer
// BEHAVIOUR
//   Reset: rclk and rst are a single clock and a synchronous active-high reset.
//     On rst, m_valid=0, level=0, inflight=0, discard=0, state=RUN.
//     fifo_renable is forced 0 while rst=1. m_data is don't-care.
//   Credit rule: issue = state==RUN & !fifo_empty & !flush & (level+inflight < BD).
//     fifo_renable = issue. inflight counts issued reads not yet returned (0..RD_LAT).
//   Return tracking: an RD_LAT-deep valid shift pipe carries issue. At the pipe
//     output, fifo_rdata is written at the buffer tail, or dropped if discard>0.
//   Buffer: circular, BD entries. Pointers wrap modulo BD.
//     pop = m_valid & m_ready. push and pop in the same cycle leave level unchanged.
//     m_valid = (level != 0). m_data = entry at the head pointer (registered storage).
//   Overflow is impossible by construction. A push with level==BD is an assertion
//     failure, not handled logic.
//   Latency: with FIFO non-empty and the buffer empty, m_valid rises RD_LAT+1
//     cycles after the first fifo_renable (1 for issue, RD_LAT for return, then
//     registered write).
//   Throughput: with fifo_empty=0 and m_ready=1, one word per cycle after fill.
//   States:
//     RUN   normal operation.
//     FLUSH entered on flush. Buffer cleared: level=0, pointers=0, m_valid=0
//           next cycle. discard loads the inflight count, so every return still
//           in the pipe is dropped. No issue while in FLUSH.
//           Returns to RUN once discard==0 and the pipe is empty.
//           If inflight==0 at the flush, FLUSH lasts 1 cycle.
//   flush while in FLUSH: ignored, because discard already covers the in-flight reads.
//   flush coincident with pop: the pop is accepted (handshake completes), then the
//     buffer is cleared.
//   Reset mid-operation: in-flight returns after rst deasserts are dropped, because
//     the pipe valids are cleared by rst. This is safe only if the FIFO is reset too.
//   fifo_empty rising while reads are in flight: the outstanding reads still
//     complete. No new reads are issued.
// STRUCTURE
//   sync_fifo_pkg: typedef enum logic {RUN, FLUSH} rd_stream_state_t;
//     function clog2-based width helpers shared with sync_fifo_rdctrl.
//   Sub-module sync_fifo_rd_pipe #(RD_LAT): synchronous-reset valid shift
//     register. Inputs issue and kill; output ret_valid.
//   Top: credit counters, FLUSH FSM, circular buffer with head/tail pointers.
// TESTING
//   1 Reset: rst=1 for 3 cycles with fifo_empty=0 -> fifo_renable=0, m_valid=0,
//     level=0 throughout.
//   2 Streaming: preload 10 words 0x100..0x109, m_ready=1 -> m_data 0x100..0x109
//     in order on consecutive cycles; first m_valid 2 cycles after first renable
//     (RD_LAT=1).
//   3 Backpressure: m_ready=0 with the FIFO non-empty -> exactly BD=3 renables,
//     level=3, m_data held. Release -> no loss, no duplicates.
//   4 Empty boundary: FIFO holds 1 word -> a single renable, m_valid for one word,
//     then m_valid=0 and fifo_renable=0 while empty.
//   5 Flush: flush with inflight=1 and level=2 -> next cycle m_valid=0; the
//     in-flight word is dropped; the next word seen at m_data is the FIFO's next
//     unread word.
//   6 Wrap and reset: randomised m_ready over 1000 words (scoreboard checks
//     order); pointer wrap covered; rst mid-stream gives the step-1 values.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared state type and width helpers for the sync_fifo read side
package sync_fifo_pkg;
  typedef enum logic {RUN, FLUSH} rd_stream_state_t;
  function automatic int cnt_w(int n);
    return $clog2(n + 1);
  endfunction
  function automatic int ptr_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sync_fifo_rd_pipe.sv
// sync_fifo_rd_pipe: RD_LAT-deep valid shift register marking when an issued read returns
module sync_fifo_rd_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic rclk,
  input  logic kill,
  input  logic issue,
  output logic ret_valid
);
  logic [RD_LAT-1:0] sr;
  always_ff @(posedge rclk) sr <= kill ? '0 : (sr << 1) | RD_LAT'(issue);
  assign ret_valid = sr[RD_LAT-1];
endmodule

// File: rtl/sync_fifo_rd_stream.sv
// sync_fifo_rd_stream: FIFO read port to valid/ready stream with credit-based prefetch buffer
module sync_fifo_rd_stream
  import sync_fifo_pkg::*;
#(
  parameter int DW = 32,
  parameter int RD_LAT = 1,
  localparam int BD = RD_LAT + 2,
  localparam int LW = cnt_w(BD),
  localparam int IW = cnt_w(RD_LAT),
  localparam int PW = ptr_w(BD)
) (
  input  logic          rclk,
  input  logic          rst,
  input  logic          fifo_empty,
  output logic          fifo_renable,
  input  logic [DW-1:0] fifo_rdata,
  input  logic          flush,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready,
  output logic [LW-1:0] level
);
  rd_stream_state_t state, state_n;
  logic [IW-1:0] inflight, discard, discard_n;
  logic [PW-1:0] head, tail;
  logic [DW-1:0] mem [BD];
  logic issue, ret_valid, push, pop, clear;
  function automatic logic [PW-1:0] nxt(logic [PW-1:0] p);
    return p == PW'(BD - 1) ? '0 : p + 1'b1;
  endfunction
  // credits count buffered plus in-flight words so a return always has a free slot
  assign issue = !rst && state == RUN && !fifo_empty && !flush && (int'(level) + int'(inflight) < BD);
  assign fifo_renable = issue;
  assign push = ret_valid && discard == '0;
  assign pop = m_valid && m_ready;
  assign clear = state == RUN && flush;
  assign m_valid = level != '0;
  assign m_data = mem[head];
  sync_fifo_rd_pipe #(.RD_LAT(RD_LAT)) u_pipe (
    .rclk(rclk),
    .kill(rst),
    .issue(issue),
    .ret_valid(ret_valid)
  );
  always_comb begin
    state_n = state == RUN ? (flush ? FLUSH : RUN) : (discard == '0 && inflight == '0 ? RUN : FLUSH);
    discard_n = clear ? inflight - IW'(ret_valid) : discard - IW'(ret_valid && discard != '0);
  end
  always_ff @(posedge rclk) begin
    if (rst) begin
      state <= RUN;
      inflight <= '0;
      discard <= '0;
      level <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      state <= state_n;
      inflight <= inflight + IW'(issue) - IW'(ret_valid);
      discard <= discard_n;
      level <= clear ? '0 : level + LW'(push) - LW'(pop);
      head <= clear ? '0 : pop ? nxt(head) : head;
      tail <= clear ? '0 : push ? nxt(tail) : tail;
    end
  end
  always_ff @(posedge rclk) if (push) mem[tail] <= fifo_rdata;
  always_ff @(posedge rclk) if (!rst) assert (!(push && level == LW'(BD)));
endmodule
